// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: hazard/memory status in, per-stage advance/flush out.
// Latency: purely wiring; timing is set by the modules on either side.
// Backpressure: stalls are expressed by dropping the per-stage enables.
interface pipeline_ctrl_if;
  // status from the datapath
  logic        ihit;
  logic        dhit;
  logic        dmemREN;
  logic        dmemWEN;
  logic        halt;
  logic        idex_memread;
  logic [4:0]  idex_rd;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        branch_taken;
  logic        jump;
  // stage controls back to the datapath
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  // observability
  logic        halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  // controller side
  modport master (
    input  ihit, dhit, dmemREN, dmemWEN, halt, idex_memread, idex_rd,
           ifid_rs, ifid_rt, branch_taken, jump,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, state, stall_cnt
  );

  // datapath side
  modport slave (
    output ihit, dhit, dmemREN, dmemWEN, halt, idex_memread, idex_rd,
           ifid_rs, ifid_rt, branch_taken, jump,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, state, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: stage enables/flushes, data-wait FSM, halt, stall counter.
// Latency: enables/flushes combinational from state+inputs; state/halted/stall_cnt registered.
// Backpressure: a pending data access or missing ihit freezes stages by clearing enables.
module pipeline_ctrl (
  input  logic           CLK,
  input  logic           nRST,
  pipeline_ctrl_if.master bus
);

  localparam logic [1:0] RUN    = 2'b00;
  localparam logic [1:0] DWAIT  = 2'b01;
  localparam logic [1:0] HALTED = 2'b10;

  logic [1:0]  state_r, state_nxt;
  logic        halted_r, halted_nxt;
  logic [15:0] stall_r;

  logic memreq, memok, lu_haz, go;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush;

  // memory-request status and load-use detection against decode sources
  always_comb begin
    memreq = bus.dmemREN | bus.dmemWEN;
    memok  = !memreq | bus.dhit;
    lu_haz = bus.idex_memread && (bus.idex_rd != 5'd0) &&
             ((bus.idex_rd == bus.ifid_rs) || (bus.idex_rd == bus.ifid_rt));
  end

  // next-state and stage-control decode; "go" means the memory side is satisfied this cycle
  always_comb begin
    state_nxt   = state_r;
    halted_nxt  = halted_r;
    go          = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;

    case (state_r)
      RUN: begin
        // dhit with no outstanding request is irrelevant: memok is already 1
        if (!memok) state_nxt = DWAIT;
        else        go        = 1'b1;
      end
      DWAIT: begin
        if (bus.dhit) begin
          go        = 1'b1;
          state_nxt = RUN;
        end
      end
      HALTED: ;
      default: state_nxt = RUN;
    endcase

    if (go) begin
      if (bus.halt && bus.ihit) begin
        // let the halting instruction retire, freeze everything behind it
        memwb_en   = 1'b1;
        state_nxt  = HALTED;
        halted_nxt = 1'b1;
      end else if (bus.branch_taken) begin
        // branch resolved late: squash the three younger stages, wins over load-use
        pc_en       = bus.ihit;
        ifid_en     = bus.ihit;
        idex_en     = bus.ihit;
        exmem_en    = bus.ihit;
        memwb_en    = bus.ihit;
        ifid_flush  = bus.ihit;
        idex_flush  = bus.ihit;
        exmem_flush = bus.ihit;
      end else if (lu_haz) begin
        // hold PC and IF/ID, inject a bubble into ID/EX; a pending jump retries next cycle
        idex_en    = bus.ihit;
        idex_flush = bus.ihit;
        exmem_en   = bus.ihit;
        memwb_en   = bus.ihit;
      end else begin
        pc_en      = bus.ihit;
        ifid_en    = bus.ihit;
        idex_en    = bus.ihit;
        exmem_en   = bus.ihit;
        memwb_en   = bus.ihit;
        ifid_flush = bus.jump & bus.ihit;
      end
    end

    // nothing advances while reset is held
    if (!nRST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
    end
  end

  // FSM state and sticky halt flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r  <= RUN;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      halted_r <= halted_nxt;
    end
  end

  // count cycles where the PC is held, saturating instead of wrapping
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_r <= 16'd0;
    end else if ((state_r != HALTED) && !pc_en && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.halted      = halted_r;
  assign bus.state       = state_r;
  assign bus.stall_cnt   = stall_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed cycles push expectations, a negedge monitor pops and compares.
// Latency: each pushed expectation describes the cycle in which it is pushed.
// Backpressure: none; exactly one expectation per checked cycle.
module tb_pipeline_ctrl;

  logic CLK;
  logic nRST;

  pipeline_ctrl_if pif ();

  pipeline_ctrl dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (pif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [4:0]  en;   // {pc, ifid, idex, exmem, memwb}
    logic [2:0]  fl;   // {ifid, idex, exmem}
    logic [1:0]  st;
    logic        hl;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // monitor: compare whenever an expectation is waiting for this cycle
  initial begin
    exp_t e;
    logic [4:0] a_en;
    logic [2:0] a_fl;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e    = q.pop_front();
        a_en = {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en};
        a_fl = {pif.ifid_flush, pif.idex_flush, pif.exmem_flush};
        checks++;
        if (a_en !== e.en || a_fl !== e.fl || pif.state !== e.st ||
            pif.halted !== e.hl || pif.stall_cnt !== e.sc) begin
          errors++;
          $display("FAIL %s: got en=%b fl=%b st=%b h=%b sc=%h, want en=%b fl=%b st=%b h=%b sc=%h",
                   e.name, a_en, a_fl, pif.state, pif.halted, pif.stall_cnt,
                   e.en, e.fl, e.st, e.hl, e.sc);
        end
      end
    end
  end

  task automatic push(input string n, input logic [4:0] en, input logic [2:0] fl,
                      input logic [1:0] st, input logic hl, input logic [15:0] sc);
    exp_t e;
    e.name = n; e.en = en; e.fl = fl; e.st = st; e.hl = hl; e.sc = sc;
    q.push_back(e);
  endtask

  // advance to just after the next rising edge and restore idle inputs
  task automatic cyc();
    @(posedge CLK);
    #1;
    pif.ihit         = 1'b1;
    pif.dhit         = 1'b0;
    pif.dmemREN      = 1'b0;
    pif.dmemWEN      = 1'b0;
    pif.halt         = 1'b0;
    pif.idex_memread = 1'b0;
    pif.idex_rd      = 5'd0;
    pif.ifid_rs      = 5'd0;
    pif.ifid_rt      = 5'd0;
    pif.branch_taken = 1'b0;
    pif.jump         = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    pif.idex_memread = 1'b1;
    pif.idex_rd      = rd;
    pif.ifid_rs      = rs;
    pif.ifid_rt      = rt;
  endtask

  initial begin
    nRST = 1'b0;
    pif.ihit = 1'b1; pif.dhit = 1'b0; pif.dmemREN = 1'b0; pif.dmemWEN = 1'b0;
    pif.halt = 1'b0; pif.idex_memread = 1'b0; pif.idex_rd = 5'd0;
    pif.ifid_rs = 5'd0; pif.ifid_rt = 5'd0; pif.branch_taken = 1'b0; pif.jump = 1'b0;

    // reset held with ihit=1: everything quiet
    cyc(); push("rst_hold", 5'b00000, 3'b000, 2'b00, 1'b0, 16'd0);
    cyc(); nRST = 1'b1; push("run0", 5'b11111, 3'b000, 2'b00, 1'b0, 16'd0);
    cyc(); push("run1", 5'b11111, 3'b000, 2'b00, 1'b0, 16'd0);

    // data wait: RUN miss, two DWAIT cycles, then dhit
    cyc(); pif.dmemREN = 1'b1; push("dw_run",  5'b00000, 3'b000, 2'b00, 1'b0, 16'd0);
    cyc(); pif.dmemREN = 1'b1; push("dw_wait1", 5'b00000, 3'b000, 2'b01, 1'b0, 16'd1);
    cyc(); pif.dmemREN = 1'b1; push("dw_wait2", 5'b00000, 3'b000, 2'b01, 1'b0, 16'd2);
    cyc(); pif.dmemREN = 1'b1; pif.dhit = 1'b1;
    push("dw_hit", 5'b11111, 3'b000, 2'b01, 1'b0, 16'd3);
    cyc(); push("dw_back", 5'b11111, 3'b000, 2'b00, 1'b0, 16'd3);
    cyc(); pif.dmemWEN = 1'b1; pif.dhit = 1'b1;
    push("wr_hit_run", 5'b11111, 3'b000, 2'b00, 1'b0, 16'd3);
    cyc(); pif.dhit = 1'b1; push("dhit_ignored", 5'b11111, 3'b000, 2'b00, 1'b0, 16'd3);

    // load-use
    cyc(); set_lu(5'd5, 5'd3, 5'd5); push("lu_rt", 5'b00111, 3'b010, 2'b00, 1'b0, 16'd3);
    cyc(); set_lu(5'd0, 5'd0, 5'd0); push("lu_r0", 5'b11111, 3'b000, 2'b00, 1'b0, 16'd4);
    cyc(); set_lu(5'd7, 5'd7, 5'd2); push("lu_rs", 5'b00111, 3'b010, 2'b00, 1'b0, 16'd4);
    cyc(); set_lu(5'd7, 5'd7, 5'd2); pif.ihit = 1'b0;
    push("lu_noihit", 5'b00000, 3'b000, 2'b00, 1'b0, 16'd5);

    // branch over load-use, with and without ihit
    cyc(); set_lu(5'd5, 5'd1, 5'd5); pif.branch_taken = 1'b1;
    push("br_lu", 5'b11111, 3'b111, 2'b00, 1'b0, 16'd6);
    cyc(); set_lu(5'd5, 5'd1, 5'd5); pif.branch_taken = 1'b1; pif.ihit = 1'b0;
    push("br_noihit", 5'b00000, 3'b000, 2'b00, 1'b0, 16'd6);

    // jump alone, jump under load-use, jump with branch
    cyc(); pif.jump = 1'b1; push("jump", 5'b11111, 3'b100, 2'b00, 1'b0, 16'd7);
    cyc(); pif.jump = 1'b1; set_lu(5'd9, 5'd9, 5'd0);
    push("jump_lu", 5'b00111, 3'b010, 2'b00, 1'b0, 16'd7);
    cyc(); pif.jump = 1'b1; pif.branch_taken = 1'b1;
    push("jump_br", 5'b11111, 3'b111, 2'b00, 1'b0, 16'd8);
    cyc(); pif.ihit = 1'b0; push("noihit", 5'b00000, 3'b000, 2'b00, 1'b0, 16'd8);

    // halt without ihit is not taken; with ihit it retires and freezes
    cyc(); pif.halt = 1'b1; pif.ihit = 1'b0;
    push("halt_noihit", 5'b00000, 3'b000, 2'b00, 1'b0, 16'd9);
    cyc(); pif.halt = 1'b1; push("halt", 5'b00001, 3'b000, 2'b00, 1'b0, 16'd10);
    for (int i = 0; i < 10; i++) begin
      cyc();
      pif.branch_taken = i[0];
      pif.jump         = i[1];
      pif.dmemREN      = i[2];
      pif.dhit         = 1'b1;
      push($sformatf("halted_%0d", i), 5'b00000, 3'b000, 2'b10, 1'b1, 16'd11);
    end
    cyc(); nRST = 1'b0; push("halt_rst", 5'b00000, 3'b000, 2'b00, 1'b0, 16'd0);
    cyc(); nRST = 1'b1; push("after_rst", 5'b11111, 3'b000, 2'b00, 1'b0, 16'd0);

    // saturation: 65534 stall cycles bring the count to FFFE
    for (int i = 0; i < 65533; i++) begin
      cyc(); pif.ihit = 1'b0;
    end
    cyc(); pif.ihit = 1'b0; push("sat_fffd", 5'b00000, 3'b000, 2'b00, 1'b0, 16'hFFFD);
    cyc(); pif.ihit = 1'b0; push("sat_fffe", 5'b00000, 3'b000, 2'b00, 1'b0, 16'hFFFE);
    cyc(); pif.ihit = 1'b0; push("sat_1", 5'b00000, 3'b000, 2'b00, 1'b0, 16'hFFFF);
    cyc(); pif.ihit = 1'b0; push("sat_2", 5'b00000, 3'b000, 2'b00, 1'b0, 16'hFFFF);
    cyc(); pif.ihit = 1'b0; push("sat_3", 5'b00000, 3'b000, 2'b00, 1'b0, 16'hFFFF);
    cyc(); push("sat_hold", 5'b11111, 3'b000, 2'b00, 1'b0, 16'hFFFF);

    // every expectation must have been consumed by the monitor
    cyc();
    cyc();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
